// File: rtl/stack_pkg.sv
// Shared types for the stacking-game core: FSM state encoding, default field
// widths, the layer record and the saturating score helper.
package stack_pkg;

    localparam int XW_DEFAULT = 10;
    localparam int LW_DEFAULT = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLAY    = 3'd1,
        ST_PAUSED  = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_OVER    = 3'd4,
        ST_WIN     = 3'd5
    } state_t;

    typedef struct packed {
        logic [XW_DEFAULT-1:0] x;
        logic [XW_DEFAULT-1:0] w;
    } layer_t;

    // Score never wraps: a long game pins at 255.
    function automatic logic [7:0] score_add(input logic [7:0] s, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, s} + {7'd0, inc};
        if (sum[8]) begin
            score_add = 8'hFF;
        end else begin
            score_add = sum[7:0];
        end
    endfunction

endpackage

// File: rtl/stack_overlap.sv
// Combinational overlap of a moving block against the layer beneath it:
// trimmed left edge and width, plus miss / exact-fit flags.
module stack_overlap #(
    parameter int XW = 10
) (
    input  logic [XW-1:0] cx,
    input  logic [XW-1:0] cw,
    input  logic [XW-1:0] px,
    input  logic [XW-1:0] pw,
    output logic [XW-1:0] lo,
    output logic [XW-1:0] width,
    output logic          perfect,
    output logic          miss
);

    logic [XW:0] c_end_s;
    logic [XW:0] p_end_s;
    logic [XW:0] hi_s;

    // Right edges need one extra bit; the left edge is a plain max.
    always_comb begin
        c_end_s = {1'b0, cx} + {1'b0, cw};
        p_end_s = {1'b0, px} + {1'b0, pw};
        if (cx > px) begin
            lo = cx;
        end else begin
            lo = px;
        end
        if (c_end_s < p_end_s) begin
            hi_s = c_end_s;
        end else begin
            hi_s = p_end_s;
        end
        miss    = (hi_s <= {1'b0, lo});
        width   = hi_s[XW-1:0] - lo;
        perfect = !miss && (lo == px) && (width == pw);
    end

endmodule

// File: rtl/stack_engine.sv
// Stacking-game core: bounces the moving block, resolves drops against the
// layer below, and owns the layer table, score and end-of-game state.
module stack_engine
    import stack_pkg::*;
#(
    parameter int FIELD_W    = 640,
    parameter int BLOCK_W0   = 160,
    parameter int MAX_LAYERS = 16,
    parameter int STEP       = 4,
    parameter int XW         = XW_DEFAULT,
    parameter int LW         = LW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          pause,
    input  logic          drop,
    output logic [XW-1:0] cur_x,
    output logic [XW-1:0] cur_w,
    output logic [LW-1:0] cur_layer,
    input  logic [LW-1:0] rd_idx,
    output logic [XW-1:0] rd_x,
    output logic [XW-1:0] rd_w,
    output logic [7:0]    score,
    output logic          perfect,
    output logic          game_over,
    output logic          win
);

    localparam int IW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;
    localparam logic [XW-1:0] BASE_X  = XW'((FIELD_W - BLOCK_W0) / 2);
    localparam logic [XW-1:0] BASE_W  = XW'(BLOCK_W0);
    localparam logic [XW-1:0] STEP_X  = XW'(STEP);
    localparam logic [XW:0]   STEP_X1 = (XW+1)'(STEP);
    localparam logic [XW:0]   FIELD_X1 = (XW+1)'(FIELD_W);
    localparam logic [XW-1:0] FIELD_X = XW'(FIELD_W);
    localparam logic [LW-1:0] LAST_LAYER = LW'(MAX_LAYERS - 1);
    localparam logic [LW-1:0] LAYER_ONE  = LW'(1);

    state_t        state_r;
    state_t        state_nx;
    logic [XW-1:0] cur_x_r;
    logic [XW-1:0] cur_w_r;
    logic          dir_left_r;
    logic [LW-1:0] cur_layer_r;
    logic [7:0]    score_r;
    logic          perfect_r;
    logic          game_over_r;
    logic          win_r;
    logic [XW-1:0] tbl_x_r [MAX_LAYERS];
    logic [XW-1:0] tbl_w_r [MAX_LAYERS];

    logic          reinit_s;
    logic          move_s;
    logic          place_s;
    logic          last_s;
    logic [XW-1:0] mv_x_s;
    logic          mv_left_s;
    logic [XW:0]   right_end_s;
    logic [LW-1:0] prev_layer_s;
    logic [XW-1:0] ov_lo_s;
    logic [XW-1:0] ov_w_s;
    logic          ov_perfect_s;
    logic          ov_miss_s;

    assign prev_layer_s = cur_layer_r - LAYER_ONE;
    assign last_s       = (cur_layer_r == LAST_LAYER);

    stack_overlap #(.XW(XW)) u_overlap (
        .cx      (cur_x_r),
        .cw      (cur_w_r),
        .px      (tbl_x_r[prev_layer_s[IW-1:0]]),
        .pw      (tbl_w_r[prev_layer_s[IW-1:0]]),
        .lo      (ov_lo_s),
        .width   (ov_w_s),
        .perfect (ov_perfect_s),
        .miss    (ov_miss_s)
    );

    // Next-state decode; drop outranks pause, and a dropping cycle does not move.
    always_comb begin
        state_nx = state_r;
        reinit_s = 1'b0;
        move_s   = 1'b0;
        place_s  = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER, ST_WIN: begin
                if (start) begin
                    state_nx = ST_PLAY;
                    reinit_s = 1'b1;
                end else begin
                    state_nx = state_r;
                end
            end
            ST_PLAY: begin
                if (drop) begin
                    state_nx = ST_RESOLVE;
                end else begin
                    move_s = tick;
                    if (pause) begin
                        state_nx = ST_PAUSED;
                    end else begin
                        state_nx = ST_PLAY;
                    end
                end
            end
            ST_PAUSED: begin
                if (pause) begin
                    state_nx = ST_PLAY;
                end else begin
                    state_nx = ST_PAUSED;
                end
            end
            ST_RESOLVE: begin
                if (ov_miss_s) begin
                    state_nx = ST_OVER;
                end else begin
                    place_s = 1'b1;
                    if (last_s) begin
                        state_nx = ST_WIN;
                    end else begin
                        state_nx = ST_PLAY;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Bounce arithmetic in XW+1 bits so the right-edge test cannot wrap.
    always_comb begin
        right_end_s = {1'b0, cur_x_r} + {1'b0, cur_w_r} + STEP_X1;
        mv_x_s      = cur_x_r;
        mv_left_s   = dir_left_r;
        if (!dir_left_r) begin
            if (right_end_s > FIELD_X1) begin
                mv_x_s    = FIELD_X - cur_w_r;
                mv_left_s = 1'b1;
            end else begin
                mv_x_s    = cur_x_r + STEP_X;
                mv_left_s = 1'b0;
            end
        end else begin
            if (cur_x_r < STEP_X) begin
                mv_x_s    = {XW{1'b0}};
                mv_left_s = 1'b0;
            end else begin
                mv_x_s    = cur_x_r - STEP_X;
                mv_left_s = 1'b1;
            end
        end
    end

    // State register plus registered end-of-game flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            game_over_r <= 1'b0;
            win_r       <= 1'b0;
        end else begin
            state_r     <= state_nx;
            game_over_r <= (state_nx == ST_OVER);
            win_r       <= (state_nx == ST_WIN);
        end
    end

    // Moving block, layer index, score and the one-cycle perfect pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_x_r     <= {XW{1'b0}};
            cur_w_r     <= BASE_W;
            dir_left_r  <= 1'b0;
            cur_layer_r <= LAYER_ONE;
            score_r     <= 8'd0;
            perfect_r   <= 1'b0;
        end else if (reinit_s) begin
            cur_x_r     <= {XW{1'b0}};
            cur_w_r     <= BASE_W;
            dir_left_r  <= 1'b0;
            cur_layer_r <= LAYER_ONE;
            score_r     <= 8'd0;
            perfect_r   <= 1'b0;
        end else begin
            perfect_r <= 1'b0;
            if (move_s) begin
                cur_x_r    <= mv_x_s;
                dir_left_r <= mv_left_s;
            end
            if (place_s) begin
                perfect_r <= ov_perfect_s;
                score_r   <= score_add(score_r, ov_perfect_s ? 2'd2 : 2'd1);
                if (!last_s) begin
                    cur_layer_r <= cur_layer_r + LAYER_ONE;
                    cur_w_r     <= ov_w_s;
                    cur_x_r     <= {XW{1'b0}};
                    dir_left_r  <= 1'b0;
                end
            end
        end
    end

    // Layer table: base layer centred, all others cleared on (re)start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                tbl_x_r[i] <= {XW{1'b0}};
                tbl_w_r[i] <= {XW{1'b0}};
            end
            tbl_x_r[0] <= BASE_X;
            tbl_w_r[0] <= BASE_W;
        end else if (reinit_s) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                tbl_x_r[i] <= {XW{1'b0}};
                tbl_w_r[i] <= {XW{1'b0}};
            end
            tbl_x_r[0] <= BASE_X;
            tbl_w_r[0] <= BASE_W;
        end else if (place_s) begin
            tbl_x_r[cur_layer_r[IW-1:0]] <= ov_lo_s;
            tbl_w_r[cur_layer_r[IW-1:0]] <= ov_w_s;
        end
    end

    // Read port only exposes layers already placed.
    always_comb begin
        rd_x = {XW{1'b0}};
        rd_w = {XW{1'b0}};
        if (rd_idx < cur_layer_r) begin
            rd_x = tbl_x_r[rd_idx[IW-1:0]];
            rd_w = tbl_w_r[rd_idx[IW-1:0]];
        end else begin
            rd_x = {XW{1'b0}};
            rd_w = {XW{1'b0}};
        end
    end

    assign cur_x     = cur_x_r;
    assign cur_w     = cur_w_r;
    assign cur_layer = cur_layer_r;
    assign score     = score_r;
    assign perfect   = perfect_r;
    assign game_over = game_over_r;
    assign win       = win_r;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: directed game scenarios with literal expectations,
// then random play checked every cycle against a behavioural game model.
module tb_stack_engine;

    localparam int FW = 64;
    localparam int BW = 16;
    localparam int ML = 4;
    localparam int ST = 4;
    localparam int XW = 8;
    localparam int LW = 3;

    localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSED = 2, S_RESOLVE = 3, S_OVER = 4, S_WIN = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          tick = 1'b0, start = 1'b0, pause = 1'b0, drop = 1'b0;
    logic [LW-1:0] rd_idx = '0;
    logic [XW-1:0] cur_x, cur_w, rd_x, rd_w;
    logic [LW-1:0] cur_layer;
    logic [7:0]    score;
    logic          perfect, game_over, win;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    int m_state, m_x, m_w, m_layer, m_score;
    bit m_left, m_perfect;
    int m_lx[ML];
    int m_lw[ML];

    stack_engine #(
        .FIELD_W(FW), .BLOCK_W0(BW), .MAX_LAYERS(ML), .STEP(ST), .XW(XW), .LW(LW)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause(pause), .drop(drop),
        .cur_x(cur_x), .cur_w(cur_w), .cur_layer(cur_layer), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_w(rd_w), .score(score), .perfect(perfect),
        .game_over(game_over), .win(win)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void m_init();
        m_state = S_IDLE; m_x = 0; m_w = BW; m_left = 0; m_layer = 1;
        m_score = 0; m_perfect = 0;
        foreach (m_lx[i]) begin m_lx[i] = 0; m_lw[i] = 0; end
        m_lx[0] = (FW - BW) / 2; m_lw[0] = BW;
    endfunction

    function automatic void model_step(bit t, bit s, bit p, bit d);
        int px, pw, lo, hi;
        bit pf;
        m_perfect = 0;
        case (m_state)
            S_IDLE, S_OVER, S_WIN: if (s) begin m_init(); m_state = S_PLAY; end
            S_PLAY: begin
                if (t && !d) begin
                    if (!m_left) begin
                        if (m_x + m_w + ST > FW) begin m_x = FW - m_w; m_left = 1; end
                        else m_x += ST;
                    end else begin
                        if (m_x < ST) begin m_x = 0; m_left = 0; end
                        else m_x -= ST;
                    end
                end
                if (d) m_state = S_RESOLVE;
                else if (p) m_state = S_PAUSED;
            end
            S_PAUSED: if (p) m_state = S_PLAY;
            S_RESOLVE: begin
                px = m_lx[m_layer-1]; pw = m_lw[m_layer-1];
                lo = (m_x > px) ? m_x : px;
                hi = (m_x + m_w < px + pw) ? m_x + m_w : px + pw;
                if (hi <= lo) begin
                    m_state = S_OVER;
                end else begin
                    pf = (lo == px) && (hi - lo == pw);
                    m_lx[m_layer] = lo; m_lw[m_layer] = hi - lo;
                    m_perfect = pf;
                    m_score = m_score + (pf ? 2 : 1);
                    if (m_score > 255) m_score = 255;
                    if (m_layer == ML - 1) m_state = S_WIN;
                    else begin
                        m_layer++; m_w = hi - lo; m_x = 0; m_left = 0; m_state = S_PLAY;
                    end
                end
            end
            default: m_state = S_IDLE;
        endcase
    endfunction

    task automatic step(input bit t, input bit s, input bit p, input bit d);
        tick = t; start = s; pause = p; drop = d;
        rd_idx = LW'($urandom_range(0, 7));
        @(posedge clk);
        model_step(t, s, p, d);
        #1;
        tick = 1'b0; start = 1'b0; pause = 1'b0; drop = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_layer(input int idx, input int ex, input int ew, input string nm);
        rd_idx = LW'(idx);
        #1;
        chk({nm, "_x"}, int'(rd_x), ex);
        chk({nm, "_w"}, int'(rd_w), ew);
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int ex, ew;
            chk("cur_x", int'(cur_x), m_x);
            chk("cur_w", int'(cur_w), m_w);
            chk("cur_layer", int'(cur_layer), m_layer);
            chk("score", int'(score), m_score);
            chk("perfect", int'(perfect), int'(m_perfect));
            chk("game_over", int'(game_over), int'(m_state == S_OVER));
            chk("win", int'(win), int'(m_state == S_WIN));
            chk("in_field", int'(int'(cur_x) + int'(cur_w) <= FW), 1);
            ex = 0; ew = 0;
            if (int'(rd_idx) < m_layer) begin ex = m_lx[rd_idx]; ew = m_lw[rd_idx]; end
            chk("rd_x", int'(rd_x), ex);
            chk("rd_w", int'(rd_w), ew);
        end
    end

    initial begin
        m_init();
        chk_en = 1'b1;
        @(posedge clk); #1; rst = 1'b1;

        chk("rst_cur_x", int'(cur_x), 0);
        chk("rst_cur_w", int'(cur_w), 16);
        chk("rst_layer", int'(cur_layer), 1);
        chk("rst_score", int'(score), 0);
        read_layer(0, 24, 16, "rst_l0");

        // Bounce right then left.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(12);
        chk("x_after12", int'(cur_x), 48);
        ticks(1);
        chk("x_bounce", int'(cur_x), 48);
        ticks(1);
        chk("x_left", int'(cur_x), 44);
        ticks(12);
        chk("x_at0", int'(cur_x), 0);
        ticks(1);
        chk("x_right_again", int'(cur_x), 4);

        // Perfect drop at x=24.
        ticks(5);
        chk("x_24", int'(cur_x), 24);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("perf_pulse", int'(perfect), 1);
        chk("perf_score", int'(score), 2);
        chk("perf_layer", int'(cur_layer), 2);
        chk("perf_cur_x", int'(cur_x), 0);
        chk("perf_cur_w", int'(cur_w), 16);
        read_layer(1, 24, 16, "perf_l1");
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("perf_drop_low", int'(perfect), 0);

        // Trimmed drop, then a miss.
        ticks(7);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("trim_score", int'(score), 3);
        chk("trim_w", int'(cur_w), 12);
        read_layer(2, 28, 12, "trim_l2");
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("miss_over", int'(game_over), 1);
        chk("miss_score", int'(score), 3);

        // Fill all layers to win, then restart.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int l = 0; l < 3; l++) begin
            ticks(6);
            step(1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
        chk("win_flag", int'(win), 1);
        chk("win_score", int'(score), 6);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("restart_score", int'(score), 0);
        chk("restart_layer", int'(cur_layer), 1);
        read_layer(0, 24, 16, "restart_l0");

        // Pause freezes movement and ignores drop.
        ticks(3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("pause_x", int'(cur_x), 12);
        chk("pause_layer", int'(cur_layer), 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        chk("resume_x", int'(cur_x), 16);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("drop_tick_x", int'(cur_x), 16);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("partial_w", int'(cur_w), 8);

        // Asynchronous reset while resolving a drop that would place a layer.
        ticks(6);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        #1; rst = 1'b0;
        #1;
        m_init();
        chk("arst_x", int'(cur_x), 0);
        chk("arst_w", int'(cur_w), 16);
        chk("arst_layer", int'(cur_layer), 1);
        chk("arst_score", int'(score), 0);
        chk("arst_perfect", int'(perfect), 0);
        @(posedge clk); #1; rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("arst_after_score", int'(score), 0);
        read_layer(0, 24, 16, "arst_l0");

        // Random play.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 1) == 0,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 24) == 0);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
